// File: rtl/ext_pcpi_core_pkg.sv
// Shared constants for the ext_pcpi_core PCPI multiplier: opcode, FSM codes,
// and partial-product sequencing helpers.
package ext_pcpi_core_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_CALC = 3'b001;
    localparam logic [2:0] ST_DONE = 3'b010;

    localparam int unsigned PP_COUNT = 4;

    typedef logic [$clog2(PP_COUNT)-1:0] pp_idx_t;

    // Left shift applied to each partial product: lo*lo, lo*hi, hi*lo, hi*hi.
    function automatic logic [4:0] pp_shift(input pp_idx_t idx);
        case (idx)
            2'd0:    pp_shift = 5'd0;
            2'd3:    pp_shift = 5'd16;
            default: pp_shift = 5'd8;
        endcase
    endfunction

endpackage

// File: rtl/ext_pcpi_core_mul8x8.sv
// pcpi_mul8x8: combinational 8x8 -> 16-bit multiplier; approx=1 zeroes
// bits [1:0] of both operands before multiplying.
module pcpi_mul8x8 (
    input  logic        approx,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [7:0] a_eff;
    logic [7:0] b_eff;

    assign a_eff = approx ? {a[7:2], 2'b00} : a;
    assign b_eff = approx ? {b[7:2], 2'b00} : b;
    assign p     = 16'(a_eff) * 16'(b_eff);

endmodule

// File: rtl/ext_pcpi_core.sv
// ext_pcpi_core: PCPI co-processor computing a 16x16 unsigned product with one
// shared 8x8 multiplier over four cycles. Define APPROX_MUL_EN for approximate mode.
module ext_pcpi_core
    import ext_pcpi_core_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_ready,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_wr
);

    logic [2:0]  state;
    pp_idx_t     cnt;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] acc;

    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_approx;
    logic [15:0] pp;
    logic [31:0] acc_next;
    logic        accept;

    assign accept = pcpi_valid && (pcpi_insn[6:0] == OPCODE_CUSTOM0);

    // cnt bit 1 selects the high byte of A, bit 0 the high byte of B.
    assign mul_a = cnt[1] ? op_a[15:8] : op_a[7:0];
    assign mul_b = cnt[0] ? op_b[15:8] : op_b[7:0];

`ifdef APPROX_MUL_EN
    assign mul_approx = (cnt != 2'd0);
`else
    assign mul_approx = 1'b0;
`endif

    pcpi_mul8x8 u_mul (
        .approx (mul_approx),
        .a      (mul_a),
        .b      (mul_b),
        .p      (pp)
    );

    assign acc_next = acc + ({16'd0, pp} << pp_shift(cnt));

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_wait  <= 1'b0;
            pcpi_rd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_a      <= pcpi_rs1[15:0];
                        op_b      <= pcpi_rs2[15:0];
                        acc       <= '0;
                        cnt       <= '0;
                        pcpi_wait <= 1'b1;
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == pp_idx_t'(PP_COUNT - 1)) begin
                        state      <= ST_DONE;
                        pcpi_wait  <= 1'b0;
                        pcpi_ready <= 1'b1;
                        pcpi_wr    <= 1'b1;
                        pcpi_rd    <= acc_next;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    pcpi_ready <= 1'b0;
                    pcpi_wr    <= 1'b0;
                    pcpi_rd    <= '0;
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    pcpi_ready <= 1'b0;
                    pcpi_wr    <= 1'b0;
                    pcpi_wait  <= 1'b0;
                    pcpi_rd    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pcpi_core.sv
// Self-checking bench for ext_pcpi_core: directed and random operations
// compared against an arithmetic reference of the 16x16 product.
module tb_ext_pcpi_core;

    logic        clk;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_wr;

    int vectors;
    int miscompares;

    ext_pcpi_core dut (
        .clk        (clk),
        .resetn     (resetn),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_ready (pcpi_ready),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_wr    (pcpi_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full product of the low halves; approximate mode drops the
    // two LSBs of every byte in all cross terms except lo*lo.
    function automatic logic [31:0] model(input logic [31:0] rs1, input logic [31:0] rs2);
        longint unsigned a, b, al, ah, bl, bh;
        a  = rs1 % 65536;
        b  = rs2 % 65536;
`ifdef APPROX_MUL_EN
        al = a % 256;
        ah = a / 256;
        bl = b % 256;
        bh = b / 256;
        return 32'(al * bl
                   + ((al / 4) * 4) * ((bh / 4) * 4) * 256
                   + ((ah / 4) * 4) * ((bl / 4) * 4) * 256
                   + ((ah / 4) * 4) * ((bh / 4) * 4) * 65536);
`else
        return 32'(a * b);
`endif
    endfunction

    task automatic run_op(input string tag, input logic [31:0] insn,
                          input logic [31:0] rs1, input logic [31:0] rs2);
        int          waits;
        bit          seen;
        logic [31:0] exp;
        exp   = model(rs1, rs2);
        waits = 0;
        seen  = 0;
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            check({tag, " wait&ready"}, 64'(pcpi_wait & pcpi_ready), 64'd0);
            if (pcpi_ready) begin
                seen = 1;
            end else if (pcpi_wait) begin
                waits++;
                pcpi_rs1 = $urandom;
                pcpi_rs2 = $urandom;
            end
        end
        check({tag, " ready seen"}, 64'(seen), 64'd1);
        check({tag, " rd"}, 64'(pcpi_rd), 64'(exp));
        check({tag, " wr"}, 64'(pcpi_wr), 64'd1);
        check({tag, " wait cycles"}, 64'(waits), 64'd4);
        pcpi_valid = 1'b0;
        @(negedge clk);
        check({tag, " post ready/wr/rd/wait"},
              64'({pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}), 64'd0);
    endtask

    task automatic run_unsupported(input string tag, input logic [31:0] insn,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        repeat (2) begin
            @(negedge clk);
            check({tag, " outputs idle"},
                  64'({pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}), 64'd0);
        end
        pcpi_valid = 1'b0;
        @(negedge clk);
        check({tag, " outputs idle after"},
              64'({pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}), 64'd0);
        check({tag, " state idle"}, 64'(dut.state), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] insn;
        bit          ready_seen;
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        pcpi_valid  = 1'b0;
        pcpi_insn   = '0;
        pcpi_rs1    = '0;
        pcpi_rs2    = '0;
        #1;
        check("reset outputs", 64'({pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset state", 64'(dut.state), 64'd0);

        run_op("3x4", 32'h0000_000B, 32'd3, 32'd4);
        run_unsupported("op76", 32'h0000_0076, 32'd5, 32'd6);

        // Abort: reset pulse two cycles after the accepting edge.
        @(negedge clk);
        pcpi_valid = 1'b1;
        pcpi_insn  = 32'h0000_000B;
        pcpi_rs1   = 32'd7;
        pcpi_rs2   = 32'd8;
        @(negedge clk);
        check("abort wait after accept", 64'(pcpi_wait), 64'd1);
        pcpi_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort async clear", 64'({pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}), 64'd0);
        @(negedge clk);
        resetn     = 1'b1;
        ready_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (pcpi_ready) ready_seen = 1;
        end
        check("abort no ready", 64'(ready_seen), 64'd0);
        check("abort state idle", 64'(dut.state), 64'd0);
        check("abort outputs", 64'({pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd}), 64'd0);

        run_op("9x10", 32'h0000_000B, 32'd9, 32'd10);
        run_op("11x12", 32'h0000_000B, 32'd11, 32'd12);
        run_unsupported("op57", 32'h0000_0057, 32'd13, 32'd14);
        run_op("15x16", 32'h0000_000B, 32'd15, 32'd16);
        run_op("ffff", 32'h0000_000B, 32'h0000_FFFF, 32'h0000_FFFF);
        run_op("0103", 32'h0000_000B, 32'h0000_0103, 32'h0000_0103);
        run_op("upper ignored", 32'hFFFF_FF8B, 32'hABCD_0002, 32'h1234_0003);
`ifdef APPROX_MUL_EN
        check("model 0103 approx", 64'(model(32'h103, 32'h103)), 64'h0000_0009);
`else
        check("model ffff exact", 64'(model(32'hFFFF, 32'hFFFF)), 64'hFFFE_0001);
        check("model 0103 exact", 64'(model(32'h103, 32'h103)), 64'h0001_0609);
`endif
        check("model upper", 64'(model(32'hABCD_0002, 32'h1234_0003)), 64'd6);

        for (int i = 0; i < 24; i++) begin
            r    = $urandom;
            insn = {r[31:7], OPCODE_SEL(i)};
            if (insn[6:0] == 7'h0B)
                run_op("random op", insn, $urandom, $urandom);
            else
                run_unsupported("random bad op", insn, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Mostly supported opcodes, with an occasional random unsupported one.
    function automatic logic [6:0] OPCODE_SEL(input int i);
        logic [6:0] op;
        if (i % 4 != 3) return 7'h0B;
        op = 7'($urandom);
        if (op == 7'h0B) op = 7'h33;
        return op;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
